regfile_scoreboard: RTL and testbench
=====================================

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameter XLEN, 32, register data width in bits.
REQ-002 Parameter NREG, 32, number of architectural registers (power of 2, >=2); AW = log2(NREG).
REQ-003 Parameter NRD, 2, number of read ports (1..4).
REQ-004 Parameter INIT_BASE, 100, preload value base: reg[i] = INIT_BASE + i for i>0.
REQ-005 Port clk  input  1  rising-edge clock for all state.
REQ-006 Port rst  input  1  reset, synchronous, active-high.
REQ-007 Port rd_addr  input  NRD*AW  read addresses, port k at bits [k*AW +: AW].
REQ-008 Port rd_data  output  NRD*XLEN  read data, port k at bits [k*XLEN +: XLEN].
REQ-009 Port rd_busy  output  NRD  scoreboard busy flag of each read address.
REQ-010 Port wr_en  input  1  writeback strobe.
REQ-011 Port wr_addr  input  AW  writeback destination.
REQ-012 Port wr_data  input  XLEN  writeback value.
REQ-013 Port iss_valid  input  1  instruction issue with destination register.
REQ-014 Port iss_rd  input  AW  destination of issuing instruction.
REQ-015 Port flush  input  1  pipeline flush; clears all busy bits.
REQ-016 Port ready  output  1  high once initialisation completes.
REQ-017 Port dbg_addr  input  AW  debug read address.
REQ-018 Port dbg_data  output  XLEN  combinational contents of reg[dbg_addr] (no bypass).

Function
REQ-019 FSM states INIT and RUN; rst forces INIT with init counter = 0.
REQ-020 INIT: each cycle writes reg[cnt] = (cnt==0 ? 0 : INIT_BASE+cnt), cnt increments; after cnt==NREG-1 written, next state RUN.
REQ-021 INIT lasts exactly NREG cycles after rst deasserts; ready=0 in INIT, 1 in RUN (registered).
REQ-022 In INIT, wr_en, iss_valid and flush are ignored; rd_busy reads 0.
REQ-023 RUN: wr_en with wr_addr!=0 updates reg[wr_addr] at rising edge; wr_addr==0 discarded.
REQ-024 rd_data combinational; address 0 always returns 0.
REQ-025 Bypass: in RUN, if wr_en && wr_addr==rd_addr[k] && wr_addr!=0, rd_data[k] = wr_data same cycle.
REQ-026 Busy bit set at edge on iss_valid && iss_rd!=0; cleared at edge on wr_en for wr_addr.
REQ-027 Same register issued and written same cycle: set wins (busy stays 1).
REQ-028 rd_busy[k] = busy[rd_addr[k]] && !(wr_en && wr_addr==rd_addr[k]); busy[0] constant 0.
REQ-029 flush clears all busy bits next edge; iss_valid in the same cycle is ignored; wr_en data still written.
REQ-030 Multiple read ports with identical addresses return identical data and busy.

Reset
REQ-031 On rst edge: busy all 0, state INIT, cnt 0, ready 0; register contents rewritten by INIT sequence, not at rst edge.
REQ-032 rst asserted mid-INIT or mid-RUN restarts full INIT; in-flight wr_en/iss_valid in the rst cycle are lost.
REQ-033 rd_data/dbg_data before INIT completes are don't-care for registers not yet initialised.

Structure
REQ-034 Shared package holds state enum (INIT, RUN) and default parameter constants XLEN/NREG.
REQ-035 One sub-module, rf_scoreboard (busy vector with set/clear/flush and priority rules), instantiated once; storage, FSM and bypass in top.
REQ-036 Storage single flop array, one write port, no latches, no negedge logic.

Verification
REQ-037 rst 1 cycle, defaults -> ready=0 for 32 cycles, 1 on cycle 33; reg[5]=105, reg[31]=131, reg[0]=0.
REQ-038 RUN, wr_en, wr_addr=7, wr_data=0xDEADBEEF, rd_addr[0]=7 same cycle -> rd_data[0]=0xDEADBEEF; next cycle still 0xDEADBEEF without wr_en.
REQ-039 iss_valid iss_rd=3 -> rd_busy for addr 3 =1 next cycle; wr_en wr_addr=3 -> rd_busy 0 that cycle, busy cleared next.
REQ-040 iss_valid iss_rd=4 and wr_en wr_addr=4 same cycle -> busy[4]=1 afterward, reg[4]=wr_data.
REQ-041 wr_en wr_addr=0 data=0x55 and iss_valid iss_rd=0 -> rd_data for addr 0 =0, rd_busy 0.
REQ-042 busy on x3,x9 then flush with iss_valid iss_rd=10 -> all busy 0, x10 not busy; rst mid-RUN -> ready=0, INIT restarts, reg[7] back to 107.

Source files
------------

// File: rtl/regfile_scoreboard_pkg.sv
// Shared types and default sizing for the register file with scoreboard.
package regfile_scoreboard_pkg;

    localparam int unsigned DefXlen = 32;
    localparam int unsigned DefNreg = 32;

    // Init walks every register once; Run is normal operation.
    typedef enum logic [0:0] {
        StInit,
        StRun
    } state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit vector tracking registers with an outstanding writeback.
module rf_scoreboard #(
    parameter int unsigned NREG = 32,
    parameter int unsigned AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            set_en,
    input  logic [AW-1:0]   set_addr,
    input  logic            clr_en,
    input  logic [AW-1:0]   clr_addr,
    input  logic            flush,
    output logic [NREG-1:0] busy
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Priority low to high: clear, set (set wins on collision), flush; x0 never busy.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_addr] = 1'b0;
        end
        if (set_en) begin
            busy_d[set_addr] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    // Busy state register, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with self-initialising contents, write bypass and busy scoreboard.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int unsigned XLEN      = DefXlen,
    parameter int unsigned NREG      = DefNreg,
    parameter int unsigned NRD       = 2,
    parameter int unsigned INIT_BASE = 100,
    localparam int unsigned AW       = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]    rd_busy,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [XLEN-1:0]   wr_data,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_rd,
    input  logic              flush,
    output logic              ready,
    input  logic [AW-1:0]     dbg_addr,
    output logic [XLEN-1:0]   dbg_data
);

    localparam logic [AW-1:0] LastIdx = AW'(NREG - 1);

    state_e          state_q;
    logic [AW-1:0]   cnt_q;
    logic            ready_q;
    logic            run;

    logic [XLEN-1:0] mem_q [NREG];
    logic            we;
    logic [AW-1:0]   waddr;
    logic [XLEN-1:0] wdata;

    logic [NREG-1:0] busy;

    assign run = (state_q == StRun);

    // Init/run sequencer; ready is registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StInit;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                StInit: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LastIdx) begin
                        state_q <= StRun;
                        ready_q <= 1'b1;
                    end
                end
                StRun: begin
                    state_q <= StRun;
                end
                default: begin
                    state_q <= StInit;
                end
            endcase
        end
    end

    // Single write port: init preload in Init, writeback in Run; nothing lands in a reset cycle.
    always_comb begin
        we    = 1'b0;
        waddr = wr_addr;
        wdata = wr_data;
        if (!rst) begin
            if (state_q == StInit) begin
                we    = 1'b1;
                waddr = cnt_q;
                wdata = (cnt_q == '0) ? '0 : XLEN'(INIT_BASE) + XLEN'(cnt_q);
            end else if (wr_en && (wr_addr != '0)) begin
                we = 1'b1;
            end
        end
    end

    // Storage array, no reset: contents come from the init walk.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    rf_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (run && iss_valid),
        .set_addr (iss_rd),
        .clr_en   (run && wr_en),
        .clr_addr (wr_addr),
        .flush    (run && flush),
        .busy     (busy)
    );

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] addr;
        logic          wr_match;
        logic          bypass;

        assign addr     = rd_addr[k*AW +: AW];
        assign wr_match = wr_en && (wr_addr == addr);
        assign bypass   = run && wr_match && (addr != '0);

        assign rd_data[k*XLEN +: XLEN] = (addr == '0) ? '0 :
                                         bypass       ? wr_data : mem_q[addr];
        // A writeback in flight this cycle hides the busy bit it is about to clear.
        assign rd_busy[k] = busy[addr] && !wr_match;
    end

    assign dbg_data = mem_q[dbg_addr];
    assign ready    = ready_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard with default parameters.
module tb_regfile_scoreboard;

    logic        clk;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        flush;
    logic        ready;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    int errors = 0;
    int checks = 0;
    int n;

    regfile_scoreboard dut (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .flush     (flush),
        .ready     (ready),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Counts negedges until ready rises (0 if it never does within the bound).
    task automatic wait_ready(output int cycles);
        cycles = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic idle();
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        iss_valid = 1'b0;
        iss_rd    = '0;
        flush     = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        rd_addr  = '0;
        dbg_addr = '0;
        idle();

        // Reset and first initialisation
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 check("ready_after_rst", {63'd0, ready}, 64'd0);
        wait_ready(n);
        check("init_cycles", 64'(n), 64'd32);
        dbg_addr = 5'd5;
        #1 check("init_reg5", {32'd0, dbg_data}, 64'd105);
        dbg_addr = 5'd31;
        #1 check("init_reg31", {32'd0, dbg_data}, 64'd131);
        dbg_addr = 5'd0;
        #1 check("init_reg0", {32'd0, dbg_data}, 64'd0);
        rd_addr = {5'd31, 5'd1};
        #1 check("init_rd_pair", rd_data, {32'd131, 32'd101});

        // Write with same-cycle bypass on port 0 only
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEADBEEF;
        rd_addr = {5'd8, 5'd7};
        dbg_addr = 5'd7;
        #1 check("bypass_rd", rd_data, {32'd108, 32'hDEADBEEF});
        check("dbg_no_bypass", {32'd0, dbg_data}, 64'd107);
        @(negedge clk);
        idle();
        #1 check("written_rd7", {32'd0, rd_data[31:0]}, 64'h00000000DEADBEEF);

        // Issue to x3 then write it back
        @(negedge clk);
        iss_valid = 1'b1; iss_rd = 5'd3;
        rd_addr = {5'd3, 5'd3};
        #1 check("busy3_before_edge", {62'd0, rd_busy}, 64'd0);
        @(negedge clk);
        idle();
        #1 check("busy3_set", {62'd0, rd_busy}, 64'd3);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
        #1 check("busy3_hidden_by_wb", {62'd0, rd_busy}, 64'd0);
        check("wb3_bypass", rd_data, {32'h33, 32'h33});
        @(negedge clk);
        idle();
        #1 check("busy3_cleared", {62'd0, rd_busy}, 64'd0);

        // Issue and writeback to x4 together: set wins
        @(negedge clk);
        iss_valid = 1'b1; iss_rd = 5'd4;
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h44;
        @(negedge clk);
        idle();
        rd_addr = {5'd4, 5'd4};
        #1 check("busy4_set_wins", {62'd0, rd_busy}, 64'd3);
        check("reg4_written", rd_data, {32'h44, 32'h44});

        // x0 is never written and never busy
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h55;
        iss_valid = 1'b1; iss_rd = 5'd0;
        rd_addr = {5'd0, 5'd0};
        #1 check("x0_same_cycle", {rd_data[63:2], rd_busy}, 64'd0);
        check("x0_data_now", rd_data, 64'd0);
        @(negedge clk);
        idle();
        dbg_addr = 5'd0;
        #1 check("x0_after", {rd_data[63:2], rd_busy}, 64'd0);
        check("x0_dbg", {32'd0, dbg_data}, 64'd0);

        // Busy on x3 and x9, then flush with a concurrent issue and writeback
        @(negedge clk);
        iss_valid = 1'b1; iss_rd = 5'd3;
        @(negedge clk);
        iss_rd = 5'd9;
        @(negedge clk);
        idle();
        rd_addr = {5'd9, 5'd3};
        #1 check("busy3_9", {62'd0, rd_busy}, 64'd3);
        flush = 1'b1;
        iss_valid = 1'b1; iss_rd = 5'd10;
        wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h12;
        @(negedge clk);
        idle();
        rd_addr = {5'd9, 5'd3};
        #1 check("flush_3_9", {62'd0, rd_busy}, 64'd0);
        rd_addr = {5'd4, 5'd10};
        #1 check("flush_10_4", {62'd0, rd_busy}, 64'd0);
        dbg_addr = 5'd12;
        #1 check("flush_wb_kept", {32'd0, dbg_data}, 64'h12);

        // Reset mid-Run with in-flight writeback and issue that must be lost
        @(negedge clk);
        rst = 1'b1;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
        iss_valid = 1'b1; iss_rd = 5'd9;
        @(negedge clk);
        rst = 1'b0;
        rd_addr = {5'd9, 5'd9};
        #1 check("ready_after_rst2", {63'd0, ready}, 64'd0);
        check("busy_in_init", {62'd0, rd_busy}, 64'd0);
        wait_ready(n);
        idle();
        check("reinit_cycles", 64'(n), 64'd32);
        dbg_addr = 5'd7;
        #1 check("reinit_reg7", {32'd0, dbg_data}, 64'd107);
        dbg_addr = 5'd9;
        #1 check("reinit_reg9", {32'd0, dbg_data}, 64'd109);
        check("reinit_busy9", {62'd0, rd_busy}, 64'd0);
        dbg_addr = 5'd4;
        #1 check("reinit_reg4", {32'd0, dbg_data}, 64'd104);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
